// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage signal bundle: hazard/branch controls and the program-memory
// bus on one side, the IF/ID bundle and fault report on the other.
// The master modport is the fetch unit; the slave modport is its environment
// (decoder, program memory, hazard unit and decode stage).
interface inst_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        CS_P;
  logic [31:0] inst_rdata;
  logic [31:0] address;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        fetch_fault;
  logic [31:0] fault_addr;

  modport master (
    input  stall, branch_taken, branch_target, CS_P, inst_rdata,
    output address, if_pc, if_inst, if_valid, fetch_fault, fault_addr
  );

  modport slave (
    output stall, branch_taken, branch_target, CS_P, inst_rdata,
    input  address, if_pc, if_inst, if_valid, fetch_fault, fault_addr
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Program counter and instruction fetch stage.
// PC register -> in-flight slot (rq_pc/rq_valid) -> registered IF/ID bundle.
// A one-entry skid keeps the synchronous-read word for the in-flight PC when
// a stall arrives right after its issue, because the memory output is only
// valid for one cycle.  A fetch with CS_P low enters the sticky FAULT state,
// which only rst leaves.
// Optional feature: define PC_ALIGN_CHECK_EN to also fault on PC[1:0] != 0.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h18C0
) (
  input logic             CLK,
  input logic             rst,
  inst_fetch_unit_if.master bus
);

  typedef enum logic {RUN, FAULT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] rq_pc_q;
  logic        rq_valid_q;
  logic        just_issued_q;
  logic [31:0] skid_q;
  logic        skid_full_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_valid_q;
  logic        fetch_fault_q;
  logic [31:0] fault_addr_q;
  logic        issue_ok_d;
  logic [31:0] pc_inc_d;

  // Decide whether the fetch presented this cycle is legal.
`ifdef PC_ALIGN_CHECK_EN
  assign issue_ok_d = bus.CS_P && (pc_q[1:0] == 2'b00);
`else
  assign issue_ok_d = bus.CS_P;
`endif

  assign pc_inc_d = pc_q + 32'd4;

  // Whole fetch pipeline and RUN/FAULT state machine; branch beats stall.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      rq_pc_q       <= 32'd0;
      rq_valid_q    <= 1'b0;
      just_issued_q <= 1'b0;
      skid_q        <= 32'd0;
      skid_full_q   <= 1'b0;
      if_pc_q       <= 32'd0;
      if_inst_q     <= 32'd0;
      if_valid_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= 32'd0;
    end else if (bus.branch_taken && state_q == RUN) begin
      pc_q          <= bus.branch_target;
      rq_valid_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      skid_full_q   <= 1'b0;
      just_issued_q <= 1'b0;
    end else if (!bus.stall) begin
      if_pc_q     <= rq_pc_q;
      if_inst_q   <= skid_full_q ? skid_q : bus.inst_rdata;
      if_valid_q  <= rq_valid_q;
      skid_full_q <= 1'b0;
      if (state_q == RUN) begin
        pc_q          <= pc_inc_d;
        rq_pc_q       <= pc_q;
        rq_valid_q    <= issue_ok_d;
        just_issued_q <= 1'b1;
        if (!issue_ok_d) begin
          state_q       <= FAULT;
          fault_addr_q  <= pc_q;
          fetch_fault_q <= 1'b1;
        end
      end else begin
        rq_valid_q    <= 1'b0;
        just_issued_q <= 1'b0;
      end
    end else begin
      if (just_issued_q && !skid_full_q) begin
        skid_q      <= bus.inst_rdata;
        skid_full_q <= 1'b1;
      end
      just_issued_q <= 1'b0;
    end
  end

  assign bus.address     = pc_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_inst     = if_inst_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.fault_addr  = fault_addr_q;

endmodule
